// File: rtl/tetris_pkg.sv
// tetris_pkg: playfield defaults, coordinate width and placer state encoding
package tetris_pkg;
  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int COORD_W = 5;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
endpackage

// File: rtl/tetron_cell_addr.sv
// tetron_cell_addr: anchor plus signed offset gives a board cell and an out-of-bounds flag
module tetron_cell_addr
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic [COORD_W-1:0] anchor_row,
  input  logic [COORD_W-1:0] anchor_col,
  input  logic [COORD_W-1:0] voffset,
  input  logic [COORD_W-1:0] hoffset,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               oob
);
  logic [COORD_W:0] r, c;
  assign r = {1'b0, anchor_row} + {voffset[COORD_W-1], voffset};
  assign c = {1'b0, anchor_col} + {hoffset[COORD_W-1], hoffset};
  assign row = r[COORD_W-1:0];
  assign col = c[COORD_W-1:0];
  // bit COORD_W set means the sum went negative
  assign oob = r[COORD_W] | c[COORD_W] | (r >= (COORD_W+1)'(BOARD_H)) | (c >= (COORD_W+1)'(BOARD_W));
endmodule

// File: rtl/tetron_placer.sv
// tetron_placer: checks a piece's four cells against board occupancy and optionally locks them in
module tetron_placer
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               commit,
  input  logic [COORD_W-1:0] anchor_row,
  input  logic [COORD_W-1:0] anchor_col,
  input  logic [COORD_W-1:0] blk1_voffset,
  input  logic [COORD_W-1:0] blk1_hoffset,
  input  logic [COORD_W-1:0] blk2_voffset,
  input  logic [COORD_W-1:0] blk2_hoffset,
  input  logic [COORD_W-1:0] blk3_voffset,
  input  logic [COORD_W-1:0] blk3_hoffset,
  input  logic [COORD_W-1:0] blk4_voffset,
  input  logic [COORD_W-1:0] blk4_hoffset,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_row,
  output logic [COORD_W-1:0] rd_col,
  input  logic               rd_data,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_row,
  output logic [COORD_W-1:0] wr_col,
  output logic               busy,
  output logic               done,
  output logic               collide,
  output logic               committed
);
  state_t state, ns;
  logic [1:0] k, nk;
  logic [COORD_W-1:0] vin [4], hin [4], vq [4], hq [4];
  logic [COORD_W-1:0] ar_q, ac_q, cell_row, cell_col;
  logic commit_q, rd_pend, accept, hit, oob, collide_nxt;
  assign vin = '{blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset};
  assign hin = '{blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset};
  assign accept = state == IDLE && start;
  assign hit = (accept ? 1'b0 : collide) | (rd_pend & rd_data);
  always_comb begin
    ns = state == IDLE  ? (start ? READ : IDLE) :
         state == READ  ? (k == 2'd3 ? WAIT : READ) :
         state == WAIT  ? ((commit_q && !hit) ? WRITE : DONE) :
         state == WRITE ? (k == 2'd3 ? DONE : WRITE) : IDLE;
    nk = (state == READ || state == WRITE) ? k + 2'd1 : 2'd0;
    collide_nxt = hit | (ns == READ && oob);
  end
  // outputs are registered, so the address for the upcoming cell is computed a cycle ahead
  tetron_cell_addr #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_addr (
    .anchor_row(state == IDLE ? anchor_row : ar_q),
    .anchor_col(state == IDLE ? anchor_col : ac_q),
    .voffset   (state == IDLE ? vin[0] : vq[nk]),
    .hoffset   (state == IDLE ? hin[0] : hq[nk]),
    .row       (cell_row),
    .col       (cell_col),
    .oob       (oob)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      rd_pend <= 1'b0;
      collide <= 1'b0;
      committed <= 1'b0;
      commit_q <= 1'b0;
      rd_row <= '0;
      rd_col <= '0;
      wr_row <= '0;
      wr_col <= '0;
      ar_q <= '0;
      ac_q <= '0;
      vq <= '{default: '0};
      hq <= '{default: '0};
    end else begin
      state <= ns;
      k <= nk;
      busy <= ns != IDLE;
      done <= ns == DONE;
      rd_en <= ns == READ && !oob;
      wr_en <= ns == WRITE;
      rd_pend <= rd_en;
      collide <= collide_nxt;
      committed <= accept ? 1'b0 : committed | (state == WAIT && ns == WRITE);
      if (ns == READ) begin
        rd_row <= cell_row;
        rd_col <= cell_col;
      end
      if (ns == WRITE) begin
        wr_row <= cell_row;
        wr_col <= cell_col;
      end
      if (accept) begin
        ar_q <= anchor_row;
        ac_q <= anchor_col;
        vq <= vin;
        hq <= hin;
        commit_q <= commit;
      end
    end
  end
endmodule
